// File: rtl/ladybird_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_interconnect
// Purpose  : Request/response interconnect between the core bus masters
//            (0 = D_BUS, 1 = I_BUS) and the peripheral controllers.
//            Provides tag-based address decode, per-peripheral round-robin
//            arbitration and in-order response routing with bounded
//            outstanding transactions.
// Ports    : clk_i, reset_i (async, active high)
//            m_valid_i/m_ready_o/m_addr_i/m_we_i/m_wdata_i/m_wstrb_i
//                                     master request channel (packed per master)
//            m_resp_valid_o/m_resp_data_o  master response channel
//            p_valid_o/p_ready_i/p_addr_o/p_we_o/p_wdata_o/p_wstrb_o
//                                     peripheral request channel
//            p_resp_valid_i/p_resp_data_i  peripheral response channel
// Revision : 1.0 - initial release
// ============================================================================
module ladybird_interconnect #(
   parameter int XLEN               = 32,
   parameter int NUM_MASTER         = 2,
   parameter int NUM_PERIPHERAL     = 6,
   parameter int TAG_BITS           = 4,
   // Entry i sits at [i*TAG_BITS +: TAG_BITS]: IRAM=9, BRAM=8, DRAM=0,
   // UART=F, QSPI=D, GPIO=E.
   parameter logic [NUM_PERIPHERAL*TAG_BITS-1:0] TAG_MAP =
      {4'hE, 4'hD, 4'hF, 4'h0, 4'h8, 4'h9},
   parameter int DEFAULT_PERIPHERAL = 2,
   parameter int MAX_OUTSTANDING    = 2
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [NUM_MASTER-1:0]          m_valid_i,
   output logic [NUM_MASTER-1:0]          m_ready_o,
   input  logic [NUM_MASTER*XLEN-1:0]     m_addr_i,
   input  logic [NUM_MASTER-1:0]          m_we_i,
   input  logic [NUM_MASTER*XLEN-1:0]     m_wdata_i,
   input  logic [NUM_MASTER*XLEN/8-1:0]   m_wstrb_i,
   output logic [NUM_MASTER-1:0]          m_resp_valid_o,
   output logic [NUM_MASTER*XLEN-1:0]     m_resp_data_o,
   output logic [NUM_PERIPHERAL-1:0]      p_valid_o,
   input  logic [NUM_PERIPHERAL-1:0]      p_ready_i,
   output logic [NUM_PERIPHERAL*XLEN-1:0] p_addr_o,
   output logic [NUM_PERIPHERAL-1:0]      p_we_o,
   output logic [NUM_PERIPHERAL*XLEN-1:0] p_wdata_o,
   output logic [NUM_PERIPHERAL*XLEN/8-1:0] p_wstrb_o,
   input  logic [NUM_PERIPHERAL-1:0]      p_resp_valid_i,
   input  logic [NUM_PERIPHERAL*XLEN-1:0] p_resp_data_i
);

   localparam int TW = (NUM_PERIPHERAL > 1) ? $clog2(NUM_PERIPHERAL) : 1;
   localparam int MW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int SW = XLEN / 8;

   // Per-master state
   logic [CW-1:0] cnt_q  [NUM_MASTER];
   logic [CW-1:0] cnt_d  [NUM_MASTER];
   logic [TW-1:0] last_q [NUM_MASTER];

   // Per-peripheral state: round-robin pointer and ID FIFO of master indices
   logic [MW-1:0] rr_q   [NUM_PERIPHERAL];
   logic [MW-1:0] fifo_q [NUM_PERIPHERAL][MAX_OUTSTANDING];
   logic [PW-1:0] wr_q   [NUM_PERIPHERAL];
   logic [PW-1:0] rd_q   [NUM_PERIPHERAL];
   logic [CW-1:0] occ_q  [NUM_PERIPHERAL];
   logic [CW-1:0] occ_d  [NUM_PERIPHERAL];

   logic [TW-1:0]             tgt [NUM_MASTER];
   logic [NUM_MASTER-1:0]     elig;
   logic [NUM_PERIPHERAL-1:0] gnt_v;
   logic [NUM_PERIPHERAL-1:0] acc_p;
   logic [NUM_PERIPHERAL-1:0] pop_p;
   logic [MW-1:0]             gnt_idx  [NUM_PERIPHERAL];
   logic [MW-1:0]             head_idx [NUM_PERIPHERAL];

   function automatic logic [MW-1:0] rr_pick(input logic [MW-1:0] base, input int k);
      return MW'((int'(base) + k) % NUM_MASTER);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (int'(p) == MAX_OUTSTANDING - 1) return '0;
      return p + PW'(1);
   endfunction

   // Decode: scan downward so the lowest matching index wins.
   always_comb begin
      for (int m = 0; m < NUM_MASTER; m++) begin
         tgt[m] = TW'(DEFAULT_PERIPHERAL);
         for (int i = NUM_PERIPHERAL - 1; i >= 0; i--) begin
            if (i != DEFAULT_PERIPHERAL &&
                m_addr_i[m*XLEN + XLEN - 1 -: TAG_BITS] == TAG_MAP[i*TAG_BITS +: TAG_BITS])
               tgt[m] = TW'(i);
         end
      end
   end

   // A master with outstanding requests may only continue to the same target,
   // which keeps its responses in order across peripherals.
   always_comb begin
      for (int m = 0; m < NUM_MASTER; m++) begin
         elig[m] = m_valid_i[m] && (cnt_q[m] < CW'(MAX_OUTSTANDING)) &&
                   ((cnt_q[m] == '0) || (tgt[m] == last_q[m]));
      end
   end

   // Round-robin arbitration per peripheral; everything gated during reset.
   always_comb begin
      for (int j = 0; j < NUM_PERIPHERAL; j++) begin
         gnt_v[j]   = 1'b0;
         gnt_idx[j] = '0;
         for (int k = 0; k < NUM_MASTER; k++) begin
            if (!gnt_v[j] && !reset_i && (occ_q[j] != CW'(MAX_OUTSTANDING)) &&
                elig[rr_pick(rr_q[j], k)] && (tgt[rr_pick(rr_q[j], k)] == TW'(j))) begin
               gnt_v[j]   = 1'b1;
               gnt_idx[j] = rr_pick(rr_q[j], k);
            end
         end
         acc_p[j]    = gnt_v[j] & p_ready_i[j];
         pop_p[j]    = !reset_i && p_resp_valid_i[j] && (occ_q[j] != '0);
         head_idx[j] = fifo_q[j][rd_q[j]];
      end
   end

   // Request forwarding and response routing
   always_comb begin
      m_ready_o      = '0;
      m_resp_valid_o = '0;
      m_resp_data_o  = '0;
      p_valid_o      = gnt_v;
      p_addr_o       = '0;
      p_we_o         = '0;
      p_wdata_o      = '0;
      p_wstrb_o      = '0;
      for (int j = 0; j < NUM_PERIPHERAL; j++) begin
         for (int m = 0; m < NUM_MASTER; m++) begin
            if (gnt_v[j] && gnt_idx[j] == MW'(m)) begin
               p_addr_o[j*XLEN +: XLEN]  = m_addr_i[m*XLEN +: XLEN];
               p_we_o[j]                 = m_we_i[m];
               p_wdata_o[j*XLEN +: XLEN] = m_wdata_i[m*XLEN +: XLEN];
               p_wstrb_o[j*SW +: SW]     = m_wstrb_i[m*SW +: SW];
               m_ready_o[m]              = p_ready_i[j];
            end
            if (pop_p[j] && head_idx[j] == MW'(m)) begin
               m_resp_valid_o[m]             = 1'b1;
               m_resp_data_o[m*XLEN +: XLEN] = p_resp_data_i[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Simultaneous accept and response leave counts unchanged.
   always_comb begin
      for (int m = 0; m < NUM_MASTER; m++)
         cnt_d[m] = cnt_q[m] + CW'(m_ready_o[m]) - CW'(m_resp_valid_o[m]);
      for (int j = 0; j < NUM_PERIPHERAL; j++)
         occ_d[j] = occ_q[j] + CW'(acc_p[j]) - CW'(pop_p[j]);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int m = 0; m < NUM_MASTER; m++) begin
            cnt_q[m]  <= '0;
            last_q[m] <= TW'(DEFAULT_PERIPHERAL);
         end
         for (int j = 0; j < NUM_PERIPHERAL; j++) begin
            rr_q[j]  <= '0;
            wr_q[j]  <= '0;
            rd_q[j]  <= '0;
            occ_q[j] <= '0;
            for (int d = 0; d < MAX_OUTSTANDING; d++) fifo_q[j][d] <= '0;
         end
      end else begin
         for (int m = 0; m < NUM_MASTER; m++) begin
            cnt_q[m] <= cnt_d[m];
            if (m_ready_o[m]) last_q[m] <= tgt[m];
         end
         for (int j = 0; j < NUM_PERIPHERAL; j++) begin
            occ_q[j] <= occ_d[j];
            if (acc_p[j]) begin
               fifo_q[j][wr_q[j]] <= gnt_idx[j];
               wr_q[j]            <= ptr_inc(wr_q[j]);
               rr_q[j]            <= rr_pick(gnt_idx[j], 1);
            end
            if (pop_p[j]) rd_q[j] <= ptr_inc(rd_q[j]);
         end
      end
   end

endmodule
`default_nettype wire
